button_event_gen: RTL

Converts the debounced button levels into single-cycle event pulses for the control FSMs: press, release, long-press and auto-repeat. Sits directly downstream of the per-button debouncers, one lane per board button. Downstream logic consumes only these pulses and never edge-detects raw levels itself.

---
 rtl/btn_event_pkg.sv | 23 ++
 rtl/btn_event_lane.sv | 125 ++++++++++++
 rtl/button_event_gen.sv | 48 ++++
 3 files changed

// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event generator.
//   lane_state_e    : per-lane FSM state
//   BTN_LONG_TIME   : default press-to-long-press time in cycles (0.5 s at 100 MHz)
//   BTN_REPEAT_TIME : default auto-repeat period in cycles (0.1 s at 100 MHz)
//   BTN_COUNT       : number of buttons on the board
package btn_event_pkg;

  typedef enum logic [1:0] {
    StLockout,
    StIdle,
    StPress,
    StHold
  } lane_state_e;

  localparam int unsigned BTN_LONG_TIME   = 50_000_000;
  localparam int unsigned BTN_REPEAT_TIME = 10_000_000;
  localparam int unsigned BTN_COUNT       = 5;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_event_lane.sv
// Single button lane: turns one debounced level into press / release / long-press /
// auto-repeat pulses. All outputs are registered.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   level_i   : debounced level, 1 = pressed
//   press_o   : one-cycle pulse on a new press
//   release_o : one-cycle pulse on release
//   long_o    : one-cycle pulse once the press has lasted LONG_TIME cycles
//   repeat_o  : one-cycle pulse every REPEAT_TIME cycles after long_o while held
//   held_o    : high while the lane is in PRESS or HOLD
module btn_event_lane
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_TIME   = BTN_LONG_TIME,
  parameter int unsigned REPEAT_TIME = BTN_REPEAT_TIME
) (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  localparam int unsigned CntMax = max_u(LONG_TIME, REPEAT_TIME);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  // The counter holds the number of held edges already seen since the last clear,
  // so the threshold edge is the one where it still reads N-1.
  localparam logic [CntW-1:0] LongLast   = CntW'(LONG_TIME - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_TIME - 1);
  localparam logic [CntW-1:0] CntSat     = CntW'(CntMax);

  lane_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            repeat_q, repeat_d;
  logic            held_q, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      StLockout: begin
        // A button held through reset must be seen released before it can fire.
        if (!level_i) state_d = StIdle;
      end
      StIdle: begin
        if (level_i) begin
          state_d = StPress;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      StPress: begin
        // Release wins over a threshold reached on the same edge.
        if (!level_i) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == LongLast) begin
          state_d = StHold;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHold: begin
        if (!level_i) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == RepeatLast) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StLockout;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == StPress) || (state_d == StHold);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLockout;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;
  assign held_o    = held_q;

endmodule

// File: rtl/button_event_gen.sv
// Button event generator: one independent lane per board button, plus a combined
// any-event flag for consumers that only need to wake up.
//   clk           : system clock
//   rst           : synchronous active-high reset
//   btn_level     : debounced button levels, 1 = pressed
//   press_pulse   : per-lane one-cycle press pulse
//   release_pulse : per-lane one-cycle release pulse
//   long_pulse    : per-lane one-cycle long-press pulse
//   repeat_pulse  : per-lane one-cycle auto-repeat pulse
//   held          : per-lane level, high while pressed (PRESS or HOLD)
//   any_event     : OR of all pulse outputs in the same cycle
module button_event_gen
  import btn_event_pkg::*;
#(
  parameter int unsigned N_BTN       = BTN_COUNT,
  parameter int unsigned LONG_TIME   = BTN_LONG_TIME,
  parameter int unsigned REPEAT_TIME = BTN_REPEAT_TIME
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] held,
  output logic             any_event
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    btn_event_lane #(
      .LONG_TIME  (LONG_TIME),
      .REPEAT_TIME(REPEAT_TIME)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .level_i  (btn_level[g]),
      .press_o  (press_pulse[g]),
      .release_o(release_pulse[g]),
      .long_o   (long_pulse[g]),
      .repeat_o (repeat_pulse[g]),
      .held_o   (held[g])
    );
  end

  assign any_event = |{press_pulse, release_pulse, long_pulse, repeat_pulse};

endmodule
